// File: rtl/i2c_target_regs_if.sv
//==============================================================================
// Module   : i2c_target_regs_if
// Purpose  : Register-file side bus of the I2C target (write strobe + read port).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface i2c_target_regs_if;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_strobe;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, rd_strobe,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, rd_strobe,
    output rd_data
  );
endinterface

`default_nettype wire

// File: rtl/i2c_target_regs.sv
//==============================================================================
// Module   : i2c_target_regs
// Purpose  : I2C target mapping write transfers to register strobes and serving
//            reads from a combinational register read port.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module i2c_target_regs #(
  parameter logic [6:0] ADDR        = 7'h70,
  parameter int         SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_scl,
  input  logic               i_sda,
  output logic               o_sda_oe,
  output logic               o_busy,
  i2c_target_regs_if.master  io_regs
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_WDATA,
    S_WACK, S_RDATA, S_RACK, S_IGNORE
  } state_t;

  // Synchronizers reset high so leaving reset never looks like a START.
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
      r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise =  w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl &  r_scl_d;
  assign w_start    =  w_scl &  r_scl_d &  r_sda_d & ~w_sda;
  assign w_stop     =  w_scl &  r_scl_d & ~r_sda_d &  w_sda;

  state_t     r_state, w_state;
  logic [7:0] r_shift, w_shift;
  logic [3:0] r_bitcnt, w_bitcnt;
  logic [7:0] r_ptr, w_ptr;
  logic [7:0] r_wr_addr, w_wr_addr, r_wr_data, w_wr_data;
  logic       r_sda_oe, w_sda_oe, r_wr_en, w_wr_en;
  logic       r_rd_strobe, w_rd_strobe, r_busy, w_busy, r_mack, w_mack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= 8'h00;
      r_bitcnt    <= 4'd0;
      r_ptr       <= 8'h00;
      r_wr_addr   <= 8'h00;
      r_wr_data   <= 8'h00;
      r_sda_oe    <= 1'b0;
      r_wr_en     <= 1'b0;
      r_rd_strobe <= 1'b0;
      r_busy      <= 1'b0;
      r_mack      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_shift     <= w_shift;
      r_bitcnt    <= w_bitcnt;
      r_ptr       <= w_ptr;
      r_wr_addr   <= w_wr_addr;
      r_wr_data   <= w_wr_data;
      r_sda_oe    <= w_sda_oe;
      r_wr_en     <= w_wr_en;
      r_rd_strobe <= w_rd_strobe;
      r_busy      <= w_busy;
      r_mack      <= w_mack;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_shift     = r_shift;
    w_bitcnt    = r_bitcnt;
    // The pointer advances the cycle after each write strobe.
    w_ptr       = r_wr_en ? r_ptr + 8'd1 : r_ptr;
    w_wr_addr   = r_wr_addr;
    w_wr_data   = r_wr_data;
    w_sda_oe    = r_sda_oe;
    w_wr_en     = 1'b0;
    w_rd_strobe = 1'b0;
    w_busy      = r_busy;
    w_mack      = r_mack;

    if (w_stop) begin
      w_state  = S_IDLE;
      w_busy   = 1'b0;
      w_sda_oe = 1'b0;
      w_bitcnt = 4'd0;
    end else if (w_start) begin
      w_state  = S_ADDR;
      w_busy   = 1'b1;
      w_sda_oe = 1'b0;
      w_bitcnt = 4'd0;
    end else begin
      case (r_state)
        S_ADDR, S_PTR, S_WDATA: begin
          if (w_scl_rise) begin
            w_shift  = {r_shift[6:0], w_sda};
            w_bitcnt = r_bitcnt + 4'd1;
          end else if (w_scl_fall && r_bitcnt == 4'd8) begin
            w_bitcnt = 4'd0;
            if (r_state == S_ADDR) begin
              if (r_shift[7:1] == ADDR) begin
                w_state  = S_ADDR_ACK;
                w_sda_oe = 1'b1;
              end else begin
                w_state = S_IGNORE;
              end
            end else if (r_state == S_PTR) begin
              w_ptr    = r_shift;
              w_state  = S_WACK;
              w_sda_oe = 1'b1;
            end else begin
              w_wr_en   = 1'b1;
              w_wr_addr = r_ptr;
              w_wr_data = r_shift;
              w_state   = S_WACK;
              w_sda_oe  = 1'b1;
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_bitcnt = 4'd0;
            if (r_shift[0]) begin
              w_shift     = io_regs.rd_data;
              w_rd_strobe = 1'b1;
              w_sda_oe    = ~io_regs.rd_data[7];
              w_state     = S_RDATA;
            end else begin
              w_sda_oe = 1'b0;
              w_state  = S_PTR;
            end
          end
        end
        S_WACK: begin
          if (w_scl_fall) begin
            w_sda_oe = 1'b0;
            w_bitcnt = 4'd0;
            w_state  = S_WDATA;
          end
        end
        S_RDATA: begin
          if (w_scl_rise) begin
            w_bitcnt = r_bitcnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bitcnt == 4'd8) begin
              w_sda_oe = 1'b0;
              w_bitcnt = 4'd0;
              w_state  = S_RACK;
            end else begin
              w_shift  = {r_shift[6:0], 1'b0};
              w_sda_oe = ~r_shift[6];
            end
          end
        end
        S_RACK: begin
          // Advance on the ACK itself so rd_data is valid by the falling edge.
          if (w_scl_rise) begin
            w_mack = ~w_sda;
            if (!w_sda) w_ptr = r_ptr + 8'd1;
          end else if (w_scl_fall) begin
            w_bitcnt = 4'd0;
            if (r_mack) begin
              w_shift     = io_regs.rd_data;
              w_rd_strobe = 1'b1;
              w_sda_oe    = ~io_regs.rd_data[7];
              w_state     = S_RDATA;
            end else begin
              w_state = S_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_sda_oe          = r_sda_oe;
  assign o_busy            = r_busy;
  assign io_regs.wr_en     = r_wr_en;
  assign io_regs.wr_addr   = r_wr_addr;
  assign io_regs.wr_data   = r_wr_data;
  assign io_regs.rd_addr   = r_ptr;
  assign io_regs.rd_strobe = r_rd_strobe;

endmodule

`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
//==============================================================================
// Module   : tb_i2c_target_regs
// Purpose  : Bit-banged I2C controller with scoreboarded register-bus checks.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_i2c_target_regs;
  localparam int HP = 8;
  localparam int Q  = 2;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic o_sda_oe, o_busy;
  logic w_sda_pin;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] wr_q[$];
  logic [7:0]  strobe_q[$];

  i2c_target_regs_if regs_if ();

  assign w_sda_pin       = m_sda & ~o_sda_oe;
  assign regs_if.rd_data = ~regs_if.rd_addr;

  i2c_target_regs #(.ADDR(7'h70), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_scl    (m_scl),
    .i_sda    (w_sda_pin),
    .o_sda_oe (o_sda_oe),
    .o_busy   (o_busy),
    .io_regs  (regs_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected register-bus events as the DUT presents them.
  logic        r_prev_oe = 1'b0;
  logic [15:0] r_exp_wr;
  logic [7:0]  r_exp_rd;
  always @(negedge clk) begin
    if (!rst) begin
      if (regs_if.wr_en) begin
        if (wr_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL wr_unexpected: got addr %0h data %0h, required no write",
                   regs_if.wr_addr, regs_if.wr_data);
        end else begin
          r_exp_wr = wr_q.pop_front();
          check("wr_event", {regs_if.wr_addr, regs_if.wr_data}, r_exp_wr);
        end
        check("wr_with_ack", o_sda_oe, 1);
      end
      if (regs_if.rd_strobe) begin
        if (strobe_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rd_strobe_unexpected: got strobe at %0h, required none", regs_if.rd_addr);
        end else begin
          r_exp_rd = strobe_q.pop_front();
          check("rd_strobe_addr", regs_if.rd_addr, r_exp_rd);
        end
      end
      if (o_sda_oe !== r_prev_oe) check("sda_change_scl_low", m_scl, 0);
    end
    r_prev_oe = o_sda_oe;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    wait_cyc(Q);  m_sda = b;
    wait_cyc(HP); m_scl = 1'b1;
    wait_cyc(HP); m_scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    wait_cyc(Q);         m_sda = 1'b1;
    wait_cyc(HP);        m_scl = 1'b1;
    wait_cyc(HP/2);      b = w_sda_pin;
    wait_cyc(HP - HP/2); m_scl = 1'b0;
  endtask

  task automatic i2c_start();
    if (m_scl == 1'b0) begin
      wait_cyc(Q);  m_sda = 1'b1;
      wait_cyc(HP); m_scl = 1'b1;
    end
    wait_cyc(HP); m_sda = 1'b0;
    wait_cyc(HP); m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_cyc(Q);  m_sda = 1'b0;
    wait_cyc(HP); m_scl = 1'b1;
    wait_cyc(HP); m_sda = 1'b1;
    wait_cyc(HP);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string name);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(a);
    check(name, {31'd0, ~a}, {31'd0, exp_ack});
  endtask

  task automatic read_byte(input logic ack, input logic [7:0] exp, input string name);
    logic [7:0] d;
    logic       b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~ack);
    check(name, d, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sda_oe"},    o_sda_oe, 0);
    check({tag, "_wr_en"},     regs_if.wr_en, 0);
    check({tag, "_wr_addr"},   regs_if.wr_addr, 0);
    check({tag, "_wr_data"},   regs_if.wr_data, 0);
    check({tag, "_rd_addr"},   regs_if.rd_addr, 0);
    check({tag, "_rd_strobe"}, regs_if.rd_strobe, 0);
    check({tag, "_busy"},      o_busy, 0);
  endtask

  initial begin
    int k;
    logic a;
    wait_cyc(4);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Write burst
    i2c_start();
    check("wb_busy", o_busy, 1);
    write_byte(8'hE0, 1'b1, "wb_addr_ack");
    write_byte(8'h0A, 1'b1, "wb_ptr_ack");
    wr_q.push_back(16'h0A55); write_byte(8'h55, 1'b1, "wb_d0_ack");
    wr_q.push_back(16'h0B1F); write_byte(8'h1F, 1'b1, "wb_d1_ack");
    wr_q.push_back(16'h0CFF); write_byte(8'hFF, 1'b1, "wb_d2_ack");
    i2c_stop();
    wait_cyc(4);
    check("wb_rd_addr", regs_if.rd_addr, 8'h0D);
    check("wb_busy_after_stop", o_busy, 0);
    check("wb_writes_seen", wr_q.size(), 0);

    // Address mismatch
    i2c_start();
    write_byte(8'hE2, 1'b0, "mm_addr_nack");
    write_byte(8'h00, 1'b0, "mm_b1_nack");
    write_byte(8'h12, 1'b0, "mm_b2_nack");
    i2c_stop();
    wait_cyc(4);
    check("mm_rd_addr", regs_if.rd_addr, 8'h0D);

    // Read with pointer wrap, rd_data = ~rd_addr
    i2c_start();
    write_byte(8'hE0, 1'b1, "rd_waddr_ack");
    write_byte(8'hFE, 1'b1, "rd_ptr_ack");
    i2c_start();
    strobe_q.push_back(8'hFE);
    write_byte(8'hE1, 1'b1, "rd_raddr_ack");
    strobe_q.push_back(8'hFF);
    read_byte(1'b1, 8'h01, "rd_byte0");
    strobe_q.push_back(8'h00);
    read_byte(1'b1, 8'h00, "rd_byte1");
    read_byte(1'b0, 8'hFF, "rd_byte2");
    i2c_stop();
    wait_cyc(4);
    check("rd_final_addr", regs_if.rd_addr, 8'h00);
    check("rd_strobes_seen", strobe_q.size(), 0);

    // Aborted byte, then a normal write at the same pointer
    i2c_start();
    write_byte(8'hE0, 1'b1, "ab_addr_ack");
    write_byte(8'h05, 1'b1, "ab_ptr_ack");
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop();
    wait_cyc(4);
    check("ab_rd_addr", regs_if.rd_addr, 8'h05);
    check("ab_idle_busy", o_busy, 0);
    check("ab_idle_oe", o_sda_oe, 0);
    i2c_start();
    write_byte(8'hE0, 1'b1, "ab2_addr_ack");
    write_byte(8'h05, 1'b1, "ab2_ptr_ack");
    wr_q.push_back(16'h0577); write_byte(8'h77, 1'b1, "ab2_d_ack");
    i2c_stop();
    wait_cyc(4);
    check("ab2_rd_addr", regs_if.rd_addr, 8'h06);

    // Reset while ACKing the address
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'hE0 >> i) & 8'h01) != 8'h00);
    k = 0;
    while (!o_sda_oe && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rm_ack_driven", o_sda_oe, 1);
    wait_cyc(1);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("rm_after_rst");
    recv_bit(a);
    check("rm_no_ack9", a, 1);
    write_byte(8'h33, 1'b0, "rm_b1_nack");
    write_byte(8'h44, 1'b0, "rm_b2_nack");
    i2c_stop();
    wait_cyc(4);
    check("rm_rd_addr", regs_if.rd_addr, 8'h00);

    // Pointer wrap on write
    i2c_start();
    write_byte(8'hE0, 1'b1, "pw_addr_ack");
    write_byte(8'hFF, 1'b1, "pw_ptr_ack");
    wr_q.push_back(16'hFF11); write_byte(8'h11, 1'b1, "pw_d0_ack");
    wr_q.push_back(16'h0022); write_byte(8'h22, 1'b1, "pw_d1_ack");
    i2c_stop();
    wait_cyc(4);
    check("pw_rd_addr", regs_if.rd_addr, 8'h01);
    check("pw_writes_seen", wr_q.size(), 0);

    wait_cyc(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
